// File: rtl/fp_mul_seq.sv
// ----------------------------------------------------------------------------
// fp_mul_seq
// Sequential IEEE-754 binary floating-point multiplier (binary32 by default).
// The mantissa product comes from an iterative radix-4 Booth multiplier that
// retires one Booth digit per cycle. Operands come in, and results go out,
// through valid/ready handshakes. Only one operation is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block idle and able to accept operands
//   fp_X/fp_Y  operands, W = 1+EXP_W+FRC_W bits
//   r_mode     rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5..7 as RNE
//   out_valid  result valid; fp_Z and flags are held while it is high
//   out_ready  consumer accepts the result
//   fp_Z       product
//   ovrf, udrf, zer, inf, nan   exception flags, qualified by out_valid
// ----------------------------------------------------------------------------
module fp_mul_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned FRC_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRC_W:0]   fp_X,
    input  logic [EXP_W+FRC_W:0]   fp_Y,
    input  logic [2:0]             r_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRC_W:0]   fp_Z,
    output logic                   ovrf,
    output logic                   udrf,
    output logic                   zer,
    output logic                   inf,
    output logic                   nan
);

    localparam int unsigned W     = 1 + EXP_W + FRC_W;
    localparam int unsigned MW    = FRC_W + 1;          // mantissa with hidden bit
    localparam int unsigned PW    = 2 * MW;             // product / accumulator width
    localparam int unsigned ITER  = (FRC_W + 3) / 2;    // Booth digits for an unsigned MW-bit multiplier
    localparam int unsigned BW    = 2 * ITER;           // zero-extended multiplier width
    localparam int unsigned CNT_W = $clog2(ITER + 1);
    localparam int unsigned EW    = EXP_W + 2;          // signed exponent intermediate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [EW-1:0]    BIAS_X   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StMul,
        StRound,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   ex_q, ex_d, ey_q, ey_d;
    logic [FRC_W-1:0]   fx_q, fx_d, fy_q, fy_d;
    logic [2:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      mc_q, mc_d;      // multiplicand, pre-shifted by 2 bits per digit
    logic [BW-1:0]      mp_q, mp_d;      // multiplier, consumed 2 bits per digit
    logic               prev_q, prev_d;  // overlap bit of the Booth window
    logic [W-1:0]       z_q, z_d;
    logic               ovrf_q, ovrf_d;
    logic               udrf_q, udrf_d;
    logic               zer_q, zer_d;
    logic               inf_q, inf_d;
    logic               nan_q, nan_d;

    // ------------------------------------------------------------------------
    // Operand classification (valid in StUnpack; subnormals count as zero)
    // ------------------------------------------------------------------------
    logic x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;
    logic res_nan, res_inf, res_zero, special;

    always_comb begin
        x_zero   = (ex_q == '0);
        y_zero   = (ey_q == '0);
        x_inf    = (ex_q == EXP_ONES) && (fx_q == '0);
        y_inf    = (ey_q == EXP_ONES) && (fy_q == '0);
        x_nan    = (ex_q == EXP_ONES) && (fx_q != '0);
        y_nan    = (ey_q == EXP_ONES) && (fy_q != '0);
        res_nan  = x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero);
        res_inf  = !res_nan && (x_inf || y_inf);
        res_zero = !res_nan && !res_inf && (x_zero || y_zero);
        special  = res_nan || res_inf || res_zero;
    end

    // ------------------------------------------------------------------------
    // Radix-4 Booth digit from {mp[1:0], prev}: value in {-2,-1,0,+1,+2}
    // ------------------------------------------------------------------------
    logic [2:0]    booth_win;
    logic          booth_one, booth_two, booth_neg;
    logic [PW-1:0] booth_pp;

    always_comb begin
        booth_win = {mp_q[1:0], prev_q};
        booth_one = booth_win[1] ^ booth_win[0];
        booth_two = (booth_win == 3'b011) || (booth_win == 3'b100);
        booth_neg = booth_win[2] && !(booth_win[1] && booth_win[0]);
        booth_pp  = '0;
        if (booth_one) begin
            booth_pp = mc_q;
        end else if (booth_two) begin
            booth_pp = {mc_q[PW-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------------
    // Normalize, round and form exponent (valid in StRound)
    // Negative Booth digits make the accumulator wrap mod 2**PW; the final
    // product of two MW-bit mantissas always fits, so the wrap is harmless.
    // ------------------------------------------------------------------------
    logic             norm_n, norm_r;
    logic [FRC_W-1:0] mant, mant_r;
    logic             g_bit, r_bit, s_bit, rnd_inc;
    logic [FRC_W:0]   mant_sum;
    logic [EW-1:0]    e_sum;
    logic             e_ovf, e_udf, ovf_to_inf;
    logic [W-1:0]     rnd_z;

    always_comb begin
        norm_n = acc_q[PW-1];
        if (norm_n) begin
            mant  = acc_q[PW-2 -: FRC_W];
            g_bit = acc_q[PW-2-FRC_W];
            r_bit = acc_q[PW-3-FRC_W];
            s_bit = |acc_q[PW-4-FRC_W:0];
        end else begin
            mant  = acc_q[PW-3 -: FRC_W];
            g_bit = acc_q[PW-3-FRC_W];
            r_bit = acc_q[PW-4-FRC_W];
            s_bit = |acc_q[PW-5-FRC_W:0];
        end

        unique case (mode_q)
            RM_RTZ:  rnd_inc = 1'b0;
            RM_RDN:  rnd_inc = sign_q && (g_bit || r_bit || s_bit);
            RM_RUP:  rnd_inc = !sign_q && (g_bit || r_bit || s_bit);
            RM_RMM:  rnd_inc = g_bit;
            default: rnd_inc = g_bit && (r_bit || s_bit || mant[0]);
        endcase

        // A carry out leaves mant_r all zeros, which is exactly 1.0 x 2
        mant_sum = {1'b0, mant} + {{FRC_W{1'b0}}, rnd_inc};
        norm_r   = mant_sum[FRC_W];
        mant_r   = mant_sum[FRC_W-1:0];

        e_sum = {2'b00, ex_q} + {2'b00, ey_q} - BIAS_X
              + {{(EW-1){1'b0}}, norm_n} + {{(EW-1){1'b0}}, norm_r};
        e_ovf = !e_sum[EW-1] && (e_sum >= EXP_MAX);
        e_udf = e_sum[EW-1] || (e_sum == '0);

        ovf_to_inf = (mode_q == RM_RNE) || (mode_q == RM_RMM) ||
                     ((mode_q == RM_RUP) && !sign_q) ||
                     ((mode_q == RM_RDN) && sign_q);

        if (e_ovf) begin
            rnd_z = ovf_to_inf ? {sign_q, EXP_ONES, {FRC_W{1'b0}}}
                               : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
        end else if (e_udf) begin
            rnd_z = {sign_q, {(W-1){1'b0}}};
        end else begin
            rnd_z = {sign_q, e_sum[EXP_W-1:0], mant_r};
        end
    end

    // ------------------------------------------------------------------------
    // FSM and datapath next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        prev_d  = prev_q;
        z_d     = z_q;
        ovrf_d  = ovrf_q;
        udrf_d  = udrf_q;
        zer_d   = zer_q;
        inf_d   = inf_q;
        nan_d   = nan_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = fp_X[W-1] ^ fp_Y[W-1];
                    ex_d    = fp_X[W-2 -: EXP_W];
                    ey_d    = fp_Y[W-2 -: EXP_W];
                    fx_d    = fp_X[FRC_W-1:0];
                    fy_d    = fp_Y[FRC_W-1:0];
                    mode_d  = (r_mode > RM_RMM) ? RM_RNE : r_mode;
                    state_d = StUnpack;
                end
            end

            StUnpack: begin
                if (special) begin
                    ovrf_d  = 1'b0;
                    udrf_d  = 1'b0;
                    nan_d   = res_nan;
                    inf_d   = res_inf;
                    zer_d   = res_zero;
                    if (res_nan) begin
                        z_d = {1'b0, EXP_ONES, 1'b1, {(FRC_W-1){1'b0}}};
                    end else if (res_inf) begin
                        z_d = {sign_q, EXP_ONES, {FRC_W{1'b0}}};
                    end else begin
                        z_d = {sign_q, {(W-1){1'b0}}};
                    end
                    state_d = StDone;
                end else begin
                    acc_d   = '0;
                    mc_d    = {{(PW-MW){1'b0}}, 1'b1, fx_q};
                    mp_d    = {{(BW-MW){1'b0}}, 1'b1, fy_q};
                    prev_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StMul;
                end
            end

            StMul: begin
                acc_d  = booth_neg ? (acc_q - booth_pp) : (acc_q + booth_pp);
                mc_d   = {mc_q[PW-3:0], 2'b00};
                mp_d   = mp_q >> 2;
                prev_d = mp_q[1];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = StRound;
                end
            end

            StRound: begin
                z_d     = rnd_z;
                ovrf_d  = e_ovf;
                udrf_d  = !e_ovf && e_udf;
                zer_d   = !e_ovf && e_udf;
                inf_d   = e_ovf && ovf_to_inf;
                nan_d   = 1'b0;
                state_d = StDone;
            end

            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            ex_q    <= '0;
            ey_q    <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            mode_q  <= RM_RNE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            prev_q  <= 1'b0;
            z_q     <= '0;
            ovrf_q  <= 1'b0;
            udrf_q  <= 1'b0;
            zer_q   <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            prev_q  <= prev_d;
            z_q     <= z_d;
            ovrf_q  <= ovrf_d;
            udrf_q  <= udrf_d;
            zer_q   <= zer_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign fp_Z      = z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;
    assign zer       = zer_q;
    assign inf       = inf_q;
    assign nan       = nan_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_fp_mul_seq
// Bench for fp_mul_seq (binary32 defaults). Directed vectors from a table,
// randomized operands checked against an arithmetic reference model, plus
// hand-written sequences for output back-pressure and reset mid-multiply.
// Flags are compared as {ovrf, udrf, zer, inf, nan}. Cycle numbers count the
// accept edge as the end of cycle 0.
// ----------------------------------------------------------------------------
module tb_fp_mul_seq;

    localparam int ITER    = 13;
    localparam int LAT_NRM = ITER + 3;
    localparam int LAT_SPC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_X, fp_Y;
    logic [2:0]  r_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_Z;
    logic        ovrf, udrf, zer, inf, nan;
    logic [4:0]  flags;

    assign flags = {ovrf, udrf, zer, inf, nan};

    always #5 clk = ~clk;

    fp_mul_seq #(
        .EXP_W (8),
        .FRC_W (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf),
        .zer       (zer),
        .inf       (inf),
        .nan       (nan)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] z;
        logic [4:0]  f;
        logic [7:0]  lat;
    } res_t;

    // Reference: exact integer product, rounding decided from the discarded
    // remainder compared against one half ulp.
    function automatic res_t ref_mul(input logic [31:0] x, input logic [31:0] y,
                                     input logic [2:0] m);
        res_t            r;
        bit              s, inc;
        bit              xz, yz, xi, yi, xn, yn;
        int              ex, ey, e, sh, md;
        longint unsigned mx, my, p, q, rem, half;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        md = (m > 3'd4) ? 0 : int'(m);
        r.lat = 8'(LAT_SPC);
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            r.z = 32'h7FC00000; r.f = 5'b00001; return r;
        end
        if (xi || yi) begin
            r.z = {s, 8'hFF, 23'h0}; r.f = 5'b00010; return r;
        end
        if (xz || yz) begin
            r.z = {s, 31'h0}; r.f = 5'b00100; return r;
        end
        r.lat = 8'(LAT_NRM);
        mx   = 64'(x[22:0]) + (64'd1 << 23);
        my   = 64'(y[22:0]) + (64'd1 << 23);
        p    = mx * my;
        sh   = (p >= (64'd1 << 47)) ? 24 : 23;
        e    = ex + ey - 127 + (sh - 23);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        case (md)
            0:       inc = (rem > half) || ((rem == half) && q[0]);
            1:       inc = 1'b0;
            2:       inc = s && (rem != 0);
            3:       inc = !s && (rem != 0);
            default: inc = (rem >= half);
        endcase
        q = q + 64'(inc);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) begin
            if (md == 0 || md == 4 || (md == 3 && !s) || (md == 2 && s)) begin
                r.z = {s, 8'hFF, 23'h0}; r.f = 5'b10010;
            end else begin
                r.z = {s, 8'hFE, 23'h7FFFFF}; r.f = 5'b10000;
            end
        end else if (e <= 0) begin
            r.z = {s, 31'h0}; r.f = 5'b01100;
        end else begin
            r.z = {s, 8'(e), q[22:0]}; r.f = 5'b00000;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = int'($urandom_range(0, 11));
        f = 23'($urandom);
        if ($urandom_range(0, 7) == 0) f = '1;
        case (k)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
            2:       e = 8'($urandom_range(1, 254));
            3:       e = 8'($urandom_range(190, 254));
            4:       e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Called at a negedge; waits for idle, then presents one operand pair.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", 64'(in_ready), 64'd1);
        fp_X     = x;
        fp_Y     = y;
        r_mode   = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called just after the accept edge; returns at the negedge where out_valid is seen.
    task automatic wait_result(output logic [31:0] z, output logic [4:0] f, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 100);
        if (!out_valid) check("result_timeout", 64'(out_valid), 64'd1);
        z = fp_Z;
        f = flags;
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                                 input logic [2:0] m, input logic [31:0] ez,
                                 input logic [4:0] ef, input int elat);
        logic [31:0] z;
        logic [4:0]  f;
        int          cyc;
        start_op(x, y, m);
        wait_result(z, f, cyc);
        check({tag, "_z"}, 64'(z), 64'(ez));
        check({tag, "_flags"}, 64'(f), 64'(ef));
        check({tag, "_cycle"}, 64'(cyc), 64'(elat));
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  m;
        logic [31:0] z;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vecs[$];
        res_t        exp_r;
        logic [31:0] x, y, za, zb;
        logic [4:0]  fa, fb;
        logic [2:0]  m;
        int          cyc;

        vecs.push_back('{32'h40400000, 32'h40400000, 3'd1, 32'h41100000, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b10010, LAT_NRM});
        vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b10000, LAT_NRM});
        vecs.push_back('{32'h00400000, 32'h3F800000, 3'd0, 32'h00000000, 5'b00100, LAT_SPC});
        vecs.push_back('{32'h7F800000, 32'h80000000, 3'd0, 32'h7FC00000, 5'b00001, LAT_SPC});
        vecs.push_back('{32'h3F800001, 32'h3FFFFFFE, 3'd0, 32'h40000000, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h3F800001, 32'h3FFFFFFE, 3'd1, 32'h3FFFFFFF, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h3F800001, 32'h3FC00000, 3'd0, 32'h3FC00002, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h3F800001, 32'h3FC00000, 3'd2, 32'h3FC00001, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h3F800001, 32'h3FC00000, 3'd4, 32'h3FC00002, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h3F800001, 32'h3FC00000, 3'd7, 32'h3FC00002, 5'b00000, LAT_NRM});
        vecs.push_back('{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'b10010, LAT_NRM});
        vecs.push_back('{32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b10000, LAT_NRM});
        vecs.push_back('{32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 5'b01100, LAT_NRM});
        vecs.push_back('{32'h80800000, 32'h00800000, 3'd0, 32'h80000000, 5'b01100, LAT_NRM});
        vecs.push_back('{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'b00010, LAT_SPC});
        vecs.push_back('{32'h7FC00001, 32'h00000000, 3'd0, 32'h7FC00000, 5'b00001, LAT_SPC});
        vecs.push_back('{32'h3F800000, 32'hBF800000, 3'd0, 32'hBF800000, 5'b00000, LAT_NRM});
        vecs.push_back('{32'h80000000, 32'h40400000, 3'd0, 32'h80000000, 5'b00100, LAT_SPC});
        vecs.push_back('{32'hFF800000, 32'hFF800000, 3'd1, 32'h7F800000, 5'b00010, LAT_SPC});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fp_X      = '0;
        fp_Y      = '0;
        r_mode    = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_fp_z", 64'(fp_Z), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].m,
                          vecs[i].z, vecs[i].f, vecs[i].lat);
        end

        // Randomized against the reference model
        for (int i = 0; i < 300; i++) begin
            x = rand_op();
            y = rand_op();
            m = 3'($urandom_range(0, 7));
            exp_r = ref_mul(x, y, m);
            run_and_check($sformatf("rnd%0d_%h_%h_m%0d", i, x, y, m), x, y, m,
                          exp_r.z, exp_r.f, int'(exp_r.lat));
        end

        // Back-pressure: result held for 5 cycles, new request ignored until idle
        @(negedge clk);
        out_ready = 1'b0;
        exp_r = ref_mul(32'h40400000, 32'hC0A00000, 3'd0);
        start_op(32'h40400000, 32'hC0A00000, 3'd0);
        wait_result(za, fa, cyc);
        check("bp_a_z", 64'(za), 64'(exp_r.z));
        check("bp_a_cycle", 64'(cyc), 64'(LAT_NRM));
        fp_X     = 32'h40400000;
        fp_Y     = 32'h40400000;
        r_mode   = 3'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_z", k), 64'(fp_Z), 64'(za));
            check($sformatf("bp_hold%0d_flags", k), 64'(flags), 64'(fa));
            check($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(zb, fb, cyc);
        check("bp_b_z", 64'(zb), 64'h41100000);
        check("bp_b_flags", 64'(fb), 64'd0);
        check("bp_b_cycle", 64'(cyc), 64'(LAT_NRM));

        // Reset while MUL holds iteration 5
        @(negedge clk);
        start_op(32'h3F800001, 32'h3FFFFFFE, 3'd0);
        repeat (7) @(negedge clk);
        check("rst_mid_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_fp_z", 64'(fp_Z), 64'd0);
        check("rst_mid_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        exp_r = ref_mul(32'h3F800001, 32'h3FC00000, 3'd0);
        run_and_check("rst_after", 32'h3F800001, 32'h3FC00000, 3'd0,
                      exp_r.z, exp_r.f, int'(exp_r.lat));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
